// File: rtl/unit_ram_arbiter.sv
// unit_ram_arbiter: shares the single port of the unit-state RAM between the
// VGA renderer (port 0, fixed priority), the move calculator (port 1) and the
// damage applier (port 2). Ports 1/2 alternate in bounded bursts. A waiting
// port that has been starved long enough overrides VGA.
module unit_ram_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned MAX_BURST    = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [2:0]            req_we,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  output logic [2:0]            gnt,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic [DATA_W-1:0]     rd_data,
  output logic [2:0]            rd_valid
);

  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam int unsigned WAIT_W  = $clog2(STARVE_LIMIT + 1);

  // ownerIsTwo: 0 means port 1 owns the shared slot, 1 means port 2
  logic               ownerIsTwo;
  logic [BURST_W-1:0] burstCnt;
  logic [WAIT_W-1:0]  wait1;
  logic [WAIT_W-1:0]  wait2;
  logic [2:0]         rdPending;

  logic               starved1;
  logic               starved2;
  logic               ownerReq;
  logic               otherReq;
  logic               winWe;
  logic [ADDR_W-1:0]  winAddr;
  logic [DATA_W-1:0]  winWdata;

  // Grant decision: starvation override, then VGA, then bounded round-robin
  always_comb begin
    gnt      = 3'b000;
    starved1 = req[1] && (wait1 == WAIT_W'(STARVE_LIMIT));
    starved2 = req[2] && (wait2 == WAIT_W'(STARVE_LIMIT));
    ownerReq = ownerIsTwo ? req[2] : req[1];
    otherReq = ownerIsTwo ? req[1] : req[2];
    if (reset) begin
      gnt = 3'b000;
    end else if (starved1 && starved2) begin
      gnt = ownerIsTwo ? 3'b010 : 3'b100;
    end else if (starved1) begin
      gnt = 3'b010;
    end else if (starved2) begin
      gnt = 3'b100;
    end else if (req[0]) begin
      gnt = 3'b001;
    end else if (ownerReq && ((burstCnt < BURST_W'(MAX_BURST)) || !otherReq)) begin
      gnt = ownerIsTwo ? 3'b100 : 3'b010;
    end else if (otherReq) begin
      gnt = ownerIsTwo ? 3'b010 : 3'b100;
    end
  end

  // Select the winning port's access fields
  always_comb begin
    winWe    = 1'b0;
    winAddr  = '0;
    winWdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (gnt[i]) begin
        winWe    = req_we[i];
        winAddr  = req_addr[i*ADDR_W +: ADDR_W];
        winWdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // RAM command register, read-return tracking and arbitration state
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      rdPending  <= 3'b000;
      rd_valid   <= 3'b000;
      ownerIsTwo <= 1'b0;
      burstCnt   <= '0;
      wait1      <= '0;
      wait2      <= '0;
    end else begin
      ram_en <= |gnt;
      if (|gnt) begin
        ram_we    <= winWe;
        ram_addr  <= winAddr;
        ram_wdata <= winWdata;
      end else begin
        ram_we <= 1'b0;
      end

      rdPending <= gnt & ~req_we;
      rd_valid  <= rdPending;

      if (gnt[1] || gnt[2]) begin
        if ((gnt[2] == ownerIsTwo) && (burstCnt < BURST_W'(MAX_BURST))) begin
          burstCnt <= burstCnt + BURST_W'(1);
        end else begin
          ownerIsTwo <= gnt[2];
          burstCnt   <= BURST_W'(1);
        end
      end

      if (gnt[1] || !req[1]) begin
        wait1 <= '0;
      end else if (wait1 != WAIT_W'(STARVE_LIMIT)) begin
        wait1 <= wait1 + WAIT_W'(1);
      end

      if (gnt[2] || !req[2]) begin
        wait2 <= '0;
      end else if (wait2 != WAIT_W'(STARVE_LIMIT)) begin
        wait2 <= wait2 + WAIT_W'(1);
      end
    end
  end

  // Read data comes straight from the RAM; rd_valid tags the owner
  assign rd_data = ram_rdata;

endmodule

// File: tb/tb_unit_ram_arbiter.sv
// Bench for unit_ram_arbiter: directed scenarios plus randomized traffic,
// checked each cycle against a behavioural model of the arbitration rules.
module tb_unit_ram_arbiter;

  localparam int unsigned ADDR_W       = 8;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned MAX_BURST    = 4;
  localparam int unsigned STARVE_LIMIT = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic [2:0]          req;
  logic [2:0]          req_we;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_wdata;
  logic [2:0]          gnt;
  logic                ram_en;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;
  logic [DATA_W-1:0]   rd_data;
  logic [2:0]          rd_valid;

  logic [ADDR_W-1:0]   addrR  [3];
  logic [DATA_W-1:0]   wdataR [3];

  assign req_addr  = {addrR[2], addrR[1], addrR[0]};
  assign req_wdata = {wdataR[2], wdataR[1], wdataR[0]};

  always #5 clk = ~clk;

  unit_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  // Synchronous write-first RAM
  logic [DATA_W-1:0] ramMem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        ramMem[ram_addr] <= ram_wdata;
        ram_rdata        <= ram_wdata;
      end else begin
        ram_rdata <= ramMem[ram_addr];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model state
  int                mOwner;
  int                mBurst;
  int                mWait [3];
  bit                mEn;
  bit                mWe;
  logic [ADDR_W-1:0] mAddr;
  logic [DATA_W-1:0] mWdata;
  logic [2:0]        mPend;
  logic [2:0]        mValid;
  logic [DATA_W-1:0] mRd;
  logic [DATA_W-1:0] shadow [256];
  int                lastWin;

  // Values seen on the DUT at the last sample point
  logic [2:0]        gntSeen;
  logic              enSeen;
  logic              weSeen;
  logic [ADDR_W-1:0] addrSeen;
  logic [2:0]        validSeen;
  logic [DATA_W-1:0] rdSeen;

  function automatic void resetModel();
    mOwner = 1;
    mBurst = 0;
    for (int i = 0; i < 3; i++) mWait[i] = 0;
    mEn = 0; mWe = 0; mAddr = '0; mWdata = '0;
    mPend = '0; mValid = '0;
  endfunction

  function automatic int pickWinner();
    bit s1;
    bit s2;
    int other;
    s1 = req[1] && (mWait[1] == int'(STARVE_LIMIT));
    s2 = req[2] && (mWait[2] == int'(STARVE_LIMIT));
    other = 3 - mOwner;
    if (reset) return -1;
    if (s1 && s2) return other;
    if (s1) return 1;
    if (s2) return 2;
    if (req[0]) return 0;
    if (req[mOwner] && (mBurst < int'(MAX_BURST) || !req[other])) return mOwner;
    if (req[other]) return other;
    return -1;
  endfunction

  // One clock: check outputs mid-cycle, then advance the model at the edge
  task automatic cycle();
    int w;
    logic [2:0] expG;
    @(negedge clk);
    w    = pickWinner();
    expG = (w < 0) ? 3'b000 : 3'(1 << w);
    gntSeen = gnt; enSeen = ram_en; weSeen = ram_we; addrSeen = ram_addr;
    validSeen = rd_valid; rdSeen = rd_data;
    checkVal("gnt", 32'(gnt), 32'(expG));
    checkVal("ram_en", 32'(ram_en), 32'(mEn));
    checkVal("ram_we", 32'(ram_we), 32'(mWe));
    checkVal("ram_addr", 32'(ram_addr), 32'(mAddr));
    checkVal("ram_wdata", 32'(ram_wdata), 32'(mWdata));
    checkVal("rd_valid", 32'(rd_valid), 32'(mValid));
    if (mValid != 3'b000) checkVal("rd_data", 32'(rd_data), 32'(mRd));
    @(posedge clk);
    if (mEn) begin
      if (mWe) shadow[mAddr] = mWdata;
      else     mRd = shadow[mAddr];
    end
    if (reset) begin
      resetModel();
      lastWin = -1;
    end else begin
      mValid = mPend;
      mPend  = (w >= 0 && !req_we[w]) ? 3'(1 << w) : 3'b000;
      if (w >= 0) begin
        mEn = 1; mWe = req_we[w]; mAddr = addrR[w]; mWdata = wdataR[w];
      end else begin
        mEn = 0; mWe = 0;
      end
      if (w == 1 || w == 2) begin
        if (w == mOwner && mBurst < int'(MAX_BURST)) mBurst++;
        else begin mOwner = w; mBurst = 1; end
      end
      for (int i = 1; i < 3; i++) begin
        if (w == i || !req[i]) mWait[i] = 0;
        else if (mWait[i] < int'(STARVE_LIMIT)) mWait[i]++;
      end
      lastWin = w;
    end
    #1;
  endtask

  task automatic setPort(input int i, input bit r, input bit we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req[i] = r; req_we[i] = we; addrR[i] = a; wdataR[i] = d;
  endtask

  task automatic doReset(input int n);
    reset = 1'b1;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] rrPat [9];
    rrPat = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b010};
    for (int i = 0; i < 256; i++) begin
      ramMem[i] = 16'(i * 37 + 5);
      shadow[i] = 16'(i * 37 + 5);
    end
    reset = 1'b1;
    req = 3'b000; req_we = 3'b000;
    for (int i = 0; i < 3; i++) begin addrR[i] = '0; wdataR[i] = '0; end
    lastWin = -1;
    @(posedge clk); #1;
    resetModel();

    // Reset with all ports requesting
    req = 3'b111;
    doReset(2);
    checkVal("reset_gnt", 32'(gntSeen), 32'd0);
    checkVal("reset_ram_en", 32'(enSeen), 32'd0);
    checkVal("reset_rd_valid", 32'(validSeen), 32'd0);
    cycle();
    checkVal("post_reset_gnt", 32'(gntSeen), 32'b001);
    req = 3'b000;
    repeat (3) cycle();

    // Single read by port 2
    ramMem[8'h15] = 16'hBEEF; shadow[8'h15] = 16'hBEEF;
    setPort(2, 1, 0, 8'h15, 16'h0);
    cycle();
    checkVal("rd_gnt", 32'(gntSeen), 32'b100);
    req = 3'b000;
    cycle();
    checkVal("rd_ram_en", 32'(enSeen), 32'd1);
    checkVal("rd_ram_we", 32'(weSeen), 32'd0);
    checkVal("rd_ram_addr", 32'(addrSeen), 32'h15);
    cycle();
    checkVal("rd_valid_p2", 32'(validSeen), 32'b100);
    checkVal("rd_data_beef", 32'(rdSeen), 32'hBEEF);

    // Round-robin bursts between ports 1 and 2
    doReset(1);
    setPort(1, 1, 0, 8'h01, 16'h0);
    setPort(2, 1, 0, 8'h02, 16'h0);
    for (int k = 0; k < 9; k++) begin
      cycle();
      checkVal($sformatf("rr_%0d", k), 32'(gntSeen), 32'(rrPat[k]));
    end
    req = 3'b000;

    // Port 1 alone keeps the slot beyond MAX_BURST
    doReset(1);
    setPort(1, 1, 1, 8'h30, 16'h1234);
    for (int k = 0; k < 10; k++) begin
      cycle();
      checkVal($sformatf("solo_%0d", k), 32'(gntSeen), 32'b010);
      wdataR[1] = 16'(wdataR[1] + 1);
    end
    req = 3'b000;

    // Starvation override against continuous VGA
    doReset(1);
    setPort(0, 1, 0, 8'h40, 16'h0);
    setPort(1, 1, 0, 8'h41, 16'h0);
    for (int k = 0; k < 11; k++) begin
      cycle();
      checkVal($sformatf("starve_%0d", k), 32'(gntSeen), (k == 8) ? 32'b010 : 32'b001);
      if (k == 8) req[1] = 1'b0;
    end
    req = 3'b000;

    // Reset while a read is in flight
    doReset(1);
    setPort(1, 1, 0, 8'h50, 16'h0);
    cycle();
    checkVal("mid_gnt", 32'(gntSeen), 32'b010);
    req = 3'b000;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    checkVal("mid_rd_valid", 32'(validSeen), 32'd0);
    checkVal("mid_ram_en", 32'(enSeen), 32'd0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (lastWin == i || !req[i]) begin
          if (int'($urandom_range(99)) < ((i == 0) ? 55 : 70)) begin
            setPort(i, 1, 1'($urandom_range(1)), 8'($urandom_range(15)), 16'($urandom));
          end else begin
            req[i] = 1'b0;
          end
        end
      end
      reset = ($urandom_range(299) == 0);
      cycle();
    end
    reset = 1'b0;
    req = 3'b000;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unit_ram_arbiter.md
# unit_ram_arbiter

Arbitrates the single port of the shared unit-state RAM between three requesters: the VGA renderer (port 0), the battlefront/move calculator (port 1) and the damage applier (port 2). VGA has fixed priority. Ports 1 and 2 share the remaining bandwidth round-robin, with bounded bursts and a starvation guard against continuous VGA traffic. The block sits between the game-core sequencer's datapath units and the synchronous-read RAM.

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 16, RAM data width
- MAX_BURST, 4, max consecutive grants to one of ports 1/2 while the other port waits (≥1)
- STARVE_LIMIT, 8, wait cycles before port 1/2 overrides VGA (≥1)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- req  in  3  access request per port, bit i = port i
- req_we  in  3  1 = write, 0 = read, per port
- req_addr  in  3*ADDR_W  port i address at [i*ADDR_W +: ADDR_W]
- req_wdata  in  3*DATA_W  port i write data at [i*DATA_W +: DATA_W]
- gnt  out  3  combinational one-hot grant; access accepted at the end of this cycle
- ram_en  out  1  registered RAM enable
- ram_we  out  1  registered RAM write enable
- ram_addr  out  ADDR_W  registered RAM address
- ram_wdata  out  DATA_W  registered RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_en with ram_we=0
- rd_data  out  DATA_W  equals ram_rdata (pass-through)
- rd_valid  out  3  registered; bit i high when rd_data belongs to port i

## Operation
- State registers:
  - owner: 1 or 2, the last granted non-VGA port; reset value 1.
  - burst_cnt: 0..MAX_BURST; reset value 0.
  - wait1, wait2: 0..STARVE_LIMIT, saturating; reset value 0.
  - rd_pending: 3 bits.
- Grant decision, combinational, at most one bit set:
  1. Starvation override. A port i in {1,2} is starved when req[i]=1 and wait_i == STARVE_LIMIT. If exactly one port is starved, grant it. If both are starved, grant the non-owner.
  2. Otherwise, if req[0]=1, grant port 0.
  3. Otherwise, among ports 1 and 2:
     - If the owner is requesting and (burst_cnt < MAX_BURST or the other port is idle), grant the owner.
     - Otherwise, if the other port is requesting, grant it.
  4. If no port is requesting, gnt = 0.
- Per edge with reset low:
  - If any gnt bit is set:
    - ram_en←1
    - ram_we, ram_addr, ram_wdata ← winner's inputs
  - If no gnt bit is set: ram_en←0, ram_we←0. ram_addr and ram_wdata hold.
  - Grant to port i in {1,2}:
    - If i==owner and burst_cnt<MAX_BURST: burst_cnt+1.
    - Otherwise: owner←i, burst_cnt←1.
  - Grants to port 0 do not change owner or burst_cnt.
  - wait_i: cleared to 0 if gnt[i]=1 or req[i]=0. Otherwise incremented, saturating at STARVE_LIMIT.
  - rd_valid ← gnt & ~req_we, one cycle late via rd_pending. See Timing.
- Requester rule: hold req, req_we, req_addr and req_wdata stable until the cycle gnt[i]=1. At that edge the requester may present its next access or drop req.
- Reset mid-operation:
  - All outputs are forced to reset values at the edge.
  - Any RAM read in flight is discarded; rd_valid is not raised for it.
  - A grant shown combinationally in the reset cycle is not executed.

## Timing
- Reset values:
  - gnt = 0 while reset=1 (gated).
  - ram_en = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0.
  - rd_valid = 0, rd_pending = 0.
  - owner = 1, burst_cnt = 0, wait1 = wait2 = 0.
- Grant latency: 0 cycles. gnt[i] rises in the same cycle as req[i] if port i wins.
- Accepted at edge t:
  - ram_* are driven during cycle t+1.
  - RAM returns data in cycle t+2.
  - rd_valid[i] = 1 in cycle t+2 only, for reads.
- Back-to-back grants are allowed every cycle. Throughput is 1 access per cycle.
- Write followed by read to the same address on consecutive grants: the read returns the new data (RAM write-first, owned by the RAM).
- A starved port always gets a grant within STARVE_LIMIT+1 cycles of raising req. It waits at most 1 extra cycle if both ports are starved simultaneously.

## Test plan
- Reset: hold reset 2 cycles with req=3'b111 → gnt=0, ram_en=0, rd_valid=0. First cycle after reset → gnt=3'b001.
- Single read: port 2 reads addr 0x15 at cycle t with ram_rdata=0xBEEF in t+2 → gnt=3'b100 at t, ram_addr=0x15 with ram_we=0 at t+1, rd_valid=3'b100 and rd_data=0xBEEF at t+2.
- Round-robin burst (MAX_BURST=4): ports 1 and 2 both request continuously from reset → grant pattern 1,1,1,1,2,2,2,2,1…
- Burst with other port idle: port 1 alone for 10 cycles → gnt=3'b010 on all 10 cycles.
- Starvation (STARVE_LIMIT=8): port 0 requests continuously and port 1 raises req at cycle 0 → gnt=3'b001 on cycles 0–7, gnt=3'b010 at cycle 8, then gnt=3'b001 again. wait1 clears on cycle 9.
- Reset mid-read: port 1 read granted at t and reset asserted at t+1 → rd_valid stays 0 in t+2, and ram_en=0 after the reset edge.
